// File: rtl/out_vc_state_ctrl_if.sv
// Handshake bundle between the VC/switch allocators (master) and the
// output-VC state controller (slave).
interface out_vc_state_ctrl_if #(
    parameter int NUM_PORTS        = 5,
    parameter int NUM_VCS          = 2,
    parameter int CREDIT_CTR_WIDTH = 3,
    parameter int VC_ID_BITS       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
);
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]                        vc_claim;
    logic [NUM_PORTS-1:0]                                     flit_sent;
    logic [NUM_PORTS-1:0][VC_ID_BITS-1:0]                     sent_vc;
    logic [NUM_PORTS-1:0]                                     sent_tail;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]                        credit_ret;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0][CREDIT_CTR_WIDTH-1:0]  credits_avail_count_r;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]                        vc_free_r;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0][2:0]                   err_r;

    modport master (
        output vc_claim, flit_sent, sent_vc, sent_tail, credit_ret,
        input  credits_avail_count_r, vc_free_r, err_r
    );

    modport slave (
        input  vc_claim, flit_sent, sent_vc, sent_tail, credit_ret,
        output credits_avail_count_r, vc_free_r, err_r
    );
endinterface

// File: rtl/out_vc_state_ctrl.sv
// Per-(port, VC) ownership FSM and downstream credit counter for a router's
// output side; every slot is independent and all outputs are registered.
module out_vc_state_ctrl #(
    parameter int NUM_PORTS        = 5,
    parameter int NUM_VCS          = 2,
    parameter int BUF_DEPTH        = 4,
    parameter int CREDIT_CTR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  arst_n,
    out_vc_state_ctrl_if.slave    bus
);
    localparam int VC_ID_BITS = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam logic [CREDIT_CTR_WIDTH-1:0] CNT_FULL = CREDIT_CTR_WIDTH'(BUF_DEPTH);
    localparam logic [CREDIT_CTR_WIDTH-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } vc_state_e;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            for (gj = 0; gj < NUM_VCS; gj++) begin : g_vc
                vc_state_e                   state_reg, state_next;
                logic [CREDIT_CTR_WIDTH-1:0] cnt_reg, cnt_next;
                logic [2:0]                  err_reg, err_next;
                logic                        free_reg, free_next;
                logic                        sent, claim, ret, accept;

                assign sent  = bus.flit_sent[gi] && (bus.sent_vc[gi] == VC_ID_BITS'(gj));
                assign claim = bus.vc_claim[gi][gj];
                assign ret   = bus.credit_ret[gi][gj];
                // Only an owned slot whose tail has not yet left may consume a credit.
                assign accept = sent && (state_reg == ACTIVE);

                always_comb begin
                    state_next = state_reg;
                    cnt_next   = cnt_reg;
                    err_next   = err_reg;

                    if (sent && !accept)
                        err_next[1] = 1'b1;
                    if (claim && (state_reg != IDLE))
                        err_next[2] = 1'b1;

                    // Counter saturates at both ends instead of wrapping.
                    if (accept && !ret && (cnt_reg == CNT_ZERO))
                        err_next[1] = 1'b1;
                    else if (ret && !accept && (cnt_reg == CNT_FULL))
                        err_next[0] = 1'b1;
                    else if (accept && !ret)
                        cnt_next = cnt_reg - 1'b1;
                    else if (ret && !accept)
                        cnt_next = cnt_reg + 1'b1;

                    case (state_reg)
                        IDLE: begin
                            if (claim)
                                state_next = ACTIVE;
                        end
                        ACTIVE: begin
                            if (accept && bus.sent_tail[gi])
                                state_next = (cnt_next == CNT_FULL) ? IDLE : DRAIN;
                        end
                        DRAIN: begin
                            if (cnt_next == CNT_FULL)
                                state_next = IDLE;
                        end
                        default: state_next = IDLE;
                    endcase

                    free_next = (state_next == IDLE);
                end

                always_ff @(posedge clk or negedge arst_n) begin
                    if (!arst_n) begin
                        state_reg <= IDLE;
                        cnt_reg   <= CNT_FULL;
                        err_reg   <= '0;
                        free_reg  <= 1'b1;
                    end else begin
                        state_reg <= state_next;
                        cnt_reg   <= cnt_next;
                        err_reg   <= err_next;
                        free_reg  <= free_next;
                    end
                end

                assign bus.credits_avail_count_r[gi][gj] = cnt_reg;
                assign bus.vc_free_r[gi][gj]             = free_reg;
                assign bus.err_r[gi][gj]                 = err_reg;
            end
        end
    endgenerate
endmodule

// File: tb/tb_out_vc_state_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic scored
// against a slot-level behavioural model.
module tb_out_vc_state_ctrl;
    localparam int NP  = 5;
    localparam int NV  = 2;
    localparam int BD  = 4;
    localparam int CW  = 3;
    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_S = 2;
    localparam int P_W = 3;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int total = 0;
    int bad = 0;

    out_vc_state_ctrl_if #(.NUM_PORTS(NP), .NUM_VCS(NV), .CREDIT_CTR_WIDTH(CW)) bus ();

    out_vc_state_ctrl #(
        .NUM_PORTS(NP), .NUM_VCS(NV), .BUF_DEPTH(BD), .CREDIT_CTR_WIDTH(CW)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: owned/draining flags, integer credit count, sticky errors.
    int         m_cnt   [NP][NV];
    bit         m_owned [NP][NV];
    bit         m_drain [NP][NV];
    logic [2:0] m_err   [NP][NV];

    task automatic model_reset();
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++) begin
                m_cnt[p][v] = BD; m_owned[p][v] = 0; m_drain[p][v] = 0; m_err[p][v] = 3'b000;
            end
    endtask

    task automatic model_step();
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++) begin
                bit snd, clm, ret, ok;
                int nxt;
                snd = bus.flit_sent[p] && (int'(bus.sent_vc[p]) == v);
                clm = bus.vc_claim[p][v];
                ret = bus.credit_ret[p][v];
                ok  = snd && m_owned[p][v] && !m_drain[p][v];
                if (snd && !ok) m_err[p][v][1] = 1'b1;
                if (clm && m_owned[p][v]) m_err[p][v][2] = 1'b1;
                nxt = m_cnt[p][v] - int'(ok) + int'(ret);
                if (nxt < 0)  begin nxt = 0;  m_err[p][v][1] = 1'b1; end
                if (nxt > BD) begin nxt = BD; m_err[p][v][0] = 1'b1; end
                if (!m_owned[p][v]) begin
                    if (clm) m_owned[p][v] = 1;
                end else if (!m_drain[p][v]) begin
                    if (ok && bus.sent_tail[p]) begin
                        if (nxt == BD) m_owned[p][v] = 0;
                        else           m_drain[p][v] = 1;
                    end
                end else if (nxt == BD) begin
                    m_owned[p][v] = 0; m_drain[p][v] = 0;
                end
                m_cnt[p][v] = nxt;
            end
    endtask

    task automatic clear_inputs();
        bus.vc_claim = '0; bus.flit_sent = '0; bus.sent_vc = '0;
        bus.sent_tail = '0; bus.credit_ret = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic send(input int p, input int v, input bit tail);
        bus.flit_sent[p] = 1'b1; bus.sent_vc[p] = 1'(v); bus.sent_tail[p] = tail;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 arst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        model_reset();
        #12;
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++) begin
                total++;
                if (bus.credits_avail_count_r[p][v] !== 3'd4 || bus.vc_free_r[p][v] !== 1'b1 || bus.err_r[p][v] !== 3'b000) begin
                    bad++;
                    $display("FAIL reset_hold p%0d v%0d: got cnt=%0d free=%b err=%b want cnt=4 free=1 err=000",
                             p, v, bus.credits_avail_count_r[p][v], bus.vc_free_r[p][v], bus.err_r[p][v]);
                end
            end
        @(negedge clk);
        arst_n = 1'b1;
        tick(); tick();
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++) begin
                total++;
                if (bus.credits_avail_count_r[p][v] !== 3'd4 || bus.vc_free_r[p][v] !== 1'b1 || bus.err_r[p][v] !== 3'b000) begin
                    bad++;
                    $display("FAIL reset_release p%0d v%0d: got cnt=%0d free=%b err=%b want cnt=4 free=1 err=000",
                             p, v, bus.credits_avail_count_r[p][v], bus.vc_free_r[p][v], bus.err_r[p][v]);
                end
            end
        $display("reset: checked all slots during and after reset");
    endtask

    task automatic test_packet_drain();
        bus.vc_claim[P_E][1] = 1'b1;
        tick();
        clear_inputs();
        total++;
        if (bus.vc_free_r[P_E][1] !== 1'b0) begin
            bad++; $display("FAIL claim_free: got %b want 0", bus.vc_free_r[P_E][1]);
        end
        for (int i = 0; i < 4; i++) begin
            send(P_E, 1, i == 3);
            tick();
            clear_inputs();
            total++;
            if (bus.credits_avail_count_r[P_E][1] !== 3'(3 - i)) begin
                bad++; $display("FAIL send_count[%0d]: got %0d want %0d", i, bus.credits_avail_count_r[P_E][1], 3 - i);
            end
            $display("packet: flit %0d sent tail=%0d cnt=%0d", i, i == 3, bus.credits_avail_count_r[P_E][1]);
        end
        total++;
        if (bus.vc_free_r[P_E][1] !== 1'b0 || bus.err_r[P_E][1] !== 3'b000) begin
            bad++; $display("FAIL drain_state: got free=%b err=%b want free=0 err=000", bus.vc_free_r[P_E][1], bus.err_r[P_E][1]);
        end
        for (int i = 0; i < 4; i++) begin
            bus.credit_ret[P_E][1] = 1'b1;
            tick();
            clear_inputs();
            total++;
            if (bus.credits_avail_count_r[P_E][1] !== 3'(i + 1) || bus.vc_free_r[P_E][1] !== (i == 3)) begin
                bad++; $display("FAIL credit_return[%0d]: got cnt=%0d free=%b want cnt=%0d free=%0d",
                                i, bus.credits_avail_count_r[P_E][1], bus.vc_free_r[P_E][1], i + 1, i == 3);
            end
            $display("packet: credit %0d returned cnt=%0d free=%b", i, bus.credits_avail_count_r[P_E][1], bus.vc_free_r[P_E][1]);
        end
    endtask

    task automatic test_single_flit();
        bus.vc_claim[P_N][0] = 1'b1;
        tick();
        clear_inputs();
        total++;
        if (bus.vc_free_r[P_N][0] !== 1'b0) begin
            bad++; $display("FAIL single_claim: got free=%b want 0", bus.vc_free_r[P_N][0]);
        end
        send(P_N, 0, 1'b1);
        bus.credit_ret[P_N][0] = 1'b1;
        tick();
        clear_inputs();
        total++;
        if (bus.credits_avail_count_r[P_N][0] !== 3'd4 || bus.vc_free_r[P_N][0] !== 1'b1 || bus.err_r[P_N][0] !== 3'b000) begin
            bad++; $display("FAIL single_flit: got cnt=%0d free=%b err=%b want cnt=4 free=1 err=000",
                            bus.credits_avail_count_r[P_N][0], bus.vc_free_r[P_N][0], bus.err_r[P_N][0]);
        end
        $display("single: tail+credit cnt=%0d free=%b", bus.credits_avail_count_r[P_N][0], bus.vc_free_r[P_N][0]);
    endtask

    task automatic test_errors();
        bus.vc_claim[P_S][0] = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            send(P_S, 0, 1'b0);
            tick();
            clear_inputs();
        end
        total++;
        if (bus.credits_avail_count_r[P_S][0] !== 3'd0 || bus.err_r[P_S][0] !== 3'b010) begin
            bad++; $display("FAIL send_underflow: got cnt=%0d err=%b want cnt=0 err=010",
                            bus.credits_avail_count_r[P_S][0], bus.err_r[P_S][0]);
        end
        bus.vc_claim[P_S][0] = 1'b1;
        tick();
        clear_inputs();
        total++;
        if (bus.err_r[P_S][0] !== 3'b110 || bus.vc_free_r[P_S][0] !== 1'b0 || bus.credits_avail_count_r[P_S][0] !== 3'd0) begin
            bad++; $display("FAIL claim_busy: got err=%b free=%b cnt=%0d want err=110 free=0 cnt=0",
                            bus.err_r[P_S][0], bus.vc_free_r[P_S][0], bus.credits_avail_count_r[P_S][0]);
        end
        bus.credit_ret[P_W][1] = 1'b1;
        tick();
        clear_inputs();
        total++;
        if (bus.credits_avail_count_r[P_W][1] !== 3'd4 || bus.err_r[P_W][1] !== 3'b001) begin
            bad++; $display("FAIL credit_overflow: got cnt=%0d err=%b want cnt=4 err=001",
                            bus.credits_avail_count_r[P_W][1], bus.err_r[P_W][1]);
        end
        send(P_W, 0, 1'b1);
        tick();
        clear_inputs();
        total++;
        if (bus.err_r[P_W][0] !== 3'b010 || bus.vc_free_r[P_W][0] !== 1'b1 || bus.credits_avail_count_r[P_W][0] !== 3'd4) begin
            bad++; $display("FAIL idle_send: got err=%b free=%b cnt=%0d want err=010 free=1 cnt=4",
                            bus.err_r[P_W][0], bus.vc_free_r[P_W][0], bus.credits_avail_count_r[P_W][0]);
        end
        $display("errors: S0 err=%b W1 err=%b W0 err=%b", bus.err_r[P_S][0], bus.err_r[P_W][1], bus.err_r[P_W][0]);
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.vc_claim[P_E][0] = 1'b1;
        tick();
        clear_inputs();
        send(P_E, 0, 1'b0);
        tick();
        clear_inputs();
        send(P_E, 0, 1'b0);
        @(posedge clk);
        #3 arst_n = 1'b0;
        #1;
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++) begin
                total++;
                if (bus.credits_avail_count_r[p][v] !== 3'd4 || bus.vc_free_r[p][v] !== 1'b1 || bus.err_r[p][v] !== 3'b000) begin
                    bad++;
                    $display("FAIL async_reset p%0d v%0d: got cnt=%0d free=%b err=%b want cnt=4 free=1 err=000",
                             p, v, bus.credits_avail_count_r[p][v], bus.vc_free_r[p][v], bus.err_r[p][v]);
                end
            end
        $display("async: reset mid-packet E0 cnt=%0d free=%b", bus.credits_avail_count_r[P_E][0], bus.vc_free_r[P_E][0]);
        clear_inputs();
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_random(input int pc, input int ps, input int pr, input int cycles);
        int fails_before;
        fails_before = bad;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            for (int p = 0; p < NP; p++) begin
                for (int v = 0; v < NV; v++) begin
                    bus.vc_claim[p][v]   = ($urandom_range(0, 99) < pc);
                    bus.credit_ret[p][v] = ($urandom_range(0, 99) < pr);
                end
                bus.flit_sent[p] = ($urandom_range(0, 99) < ps);
                bus.sent_vc[p]   = 1'($urandom_range(0, NV - 1));
                bus.sent_tail[p] = ($urandom_range(0, 99) < 30);
            end
            tick();
            for (int p = 0; p < NP; p++)
                for (int v = 0; v < NV; v++) begin
                    total++;
                    if (int'(bus.credits_avail_count_r[p][v]) != m_cnt[p][v] || $isunknown(bus.credits_avail_count_r[p][v])) begin
                        bad++; $display("FAIL rand_cnt c%0d p%0d v%0d: got %0d want %0d", c, p, v, bus.credits_avail_count_r[p][v], m_cnt[p][v]);
                    end
                    total++;
                    if (bus.vc_free_r[p][v] !== !m_owned[p][v]) begin
                        bad++; $display("FAIL rand_free c%0d p%0d v%0d: got %b want %b", c, p, v, bus.vc_free_r[p][v], !m_owned[p][v]);
                    end
                    total++;
                    if (bus.err_r[p][v] !== m_err[p][v]) begin
                        bad++; $display("FAIL rand_err c%0d p%0d v%0d: got %b want %b", c, p, v, bus.err_r[p][v], m_err[p][v]);
                    end
                end
        end
        clear_inputs();
        $display("random: pc=%0d ps=%0d pr=%0d cycles=%0d new_bad=%0d", pc, ps, pr, cycles, bad - fails_before);
    endtask

    initial begin
        test_reset();
        test_packet_drain();
        test_single_flit();
        test_errors();
        test_async_reset();
        test_random(10, 40, 35, 150);
        test_random(30, 60, 30, 150);
        test_random(5, 20, 60, 150);
        test_random(3, 15, 10, 150);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
